shift_reg_ctrl: RTL and testbench
=================================

Name: shift_reg_ctrl

Overview:
- Sequencer for the 4-bit shifting register (register4): accepts commands through a valid/ready handshake and drives the register's ENB/MODO/DIR/D/S_IN pins cycle by cycle.
- Performs three operations:
  - parallel load;
  - load-then-serialize, which emits 4 bits on a serial line;
  - load-then-rotate by N steps.
- Sits between a host command source and one register4 instance, and reports completion with a DONE pulse.

Parameters:
- CW, 3, width of the rotate step count (max rotate = 2^CW-1).
- FILL, 1'b0, bit driven on REG_S_IN while serializing.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ_VALID  input  1  command valid.
- REQ_READY  output  1  controller can accept a command.
- REQ_OP  input  2  00 = load, 01 = serialize, 10 = rotate, 11 = reserved (treated as load).
- REQ_DIR  input  1  0 = left (MSB first), 1 = right (LSB first).
- REQ_DATA  input  4  word to load.
- REQ_COUNT  input  CW  rotate steps (rotate op only).
- HOLD  input  1  pause shifting/rotating.
- REG_ENB  output  1  to register4 ENB.
- REG_MODO  output  2  to register4 MODO.
- REG_DIR  output  1  to register4 DIR.
- REG_D  output  4  to register4 D.
- REG_S_IN  output  1  to register4 S_IN.
- REG_S_OUT  input  1  from register4 S_OUT.
- SER_OUT  output  1  serial data.
- SER_VALID  output  1  SER_OUT is valid this cycle.
- BUSY  output  1  command in progress.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset state:
  - state = IDLE; latched op/dir/data/count = 0.
  - REG_ENB = 0, REG_MODO = 00, REG_DIR = 0, REG_D = 0, REG_S_IN = 0.
  - SER_VALID = 0, DONE = 0, BUSY = 0, REQ_READY = 1.
- Output timing: all outputs are decoded from registered state (Moore). SER_OUT is a combinational pass-through of REG_S_OUT.
- State machine: IDLE, LOAD, SHIFT, ROTATE, FIN.
  - IDLE: REQ_READY = 1, REG_ENB = 0. When REQ_VALID and REQ_READY are both high at an edge, latch op/dir/data/count and go to LOAD.
  - LOAD (1 cycle): REG_ENB = 1, REG_MODO = 10, REG_D = latched data. Next state:
    - serialize -> SHIFT with counter = 4;
    - rotate with count > 0 -> ROTATE with counter = count;
    - otherwise -> FIN.
  - SHIFT: REG_MODO = 00, REG_DIR = latched dir, REG_S_IN = FILL.
    - When HOLD = 0: REG_ENB = 1, SER_VALID = 1, counter decrements each edge; on the last step (counter = 1) go to FIN.
    - When HOLD = 1: REG_ENB = 0, SER_VALID = 0, counter frozen, state unchanged.
  - ROTATE: REG_MODO = 01, REG_DIR = latched dir. REG_ENB, counter and HOLD behave as in SHIFT. SER_VALID = 0.
  - FIN (1 cycle): DONE = 1, REG_ENB = 0, then go to IDLE.
- BUSY = 1 in every state except IDLE.
- Latency from the accepting edge to the DONE cycle:
  - load: 2 cycles;
  - serialize: 6 cycles;
  - rotate N: N+2 cycles.
- Serialize bit order: left emits D3, D2, D1, D0; right emits D0, D1, D2, D3. After serializing, the register holds {FILL×4}.
- REQ_* inputs are ignored while BUSY. A new command may be accepted in the cycle immediately after FIN.
- A HOLD asserted in IDLE, LOAD or FIN has no effect.
- An RST_N assertion mid-operation immediately forces IDLE and the reset outputs. The register contents are then undefined to the host, and no DONE pulse is produced.

Decomposition:
- Shared header register4_defs.vh: MODO encodings (SHIFT = 00, ROTATE = 01, LOAD = 10), REQ_OP codes, FSM state encodings.
- One sub-module: shift_step_counter, a CW+1 bit loadable down-counter with enable (frozen when HOLD = 1) and a last-step flag.

Test Plan:
- Reset: with RST_N low, check REQ_READY = 1 and REG_ENB = 0; release, idle 3 cycles, check nothing toggles.
- Serialize left, 4'b1011, FILL = 0 -> SER_VALID high for 4 cycles with SER_OUT = 1, 0, 1, 1; DONE high 6 cycles after accept; register Q = 0000.
- Serialize right, 4'b1011 with HOLD high for 2 cycles after the first bit -> SER_OUT = 1, (pause, SER_VALID = 0), 1, 0, 1; DONE delayed by 2 cycles.
- Rotate left, data 4'b0001, count 3 -> Q = 1000 at DONE; rotate with count 0 -> DONE 2 cycles after accept, Q = data.
- Load 4'b0110, then back-to-back serialize (REQ_VALID held high) -> second command accepted the cycle after the first DONE; REQ_READY low throughout BUSY.
- Pull RST_N low during SHIFT -> outputs return to reset values asynchronously, no DONE; a new command after release completes normally.

Source files
------------

// File: rtl/shift_reg_ctrl_pkg.sv
// shift_reg_ctrl_pkg: register4 pin encodings, command opcodes and sequencer states.
package shift_reg_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ROTATE, FIN} state_t;
   localparam logic [1:0] MODO_SHIFT  = 2'b00;
   localparam logic [1:0] MODO_ROTATE = 2'b01;
   localparam logic [1:0] MODO_LOAD   = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SER  = 2'b01;
   localparam logic [1:0] OP_ROT  = 2'b10;
   localparam int SER_BITS = 4;
endpackage

// File: rtl/shift_step_counter.sv
// shift_step_counter: loadable down-counter with enable; last flags the final step.
module shift_step_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] value,
   output logic         last
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= value;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   assign last = cnt == W'(1);
endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: command sequencer driving a register4 through load, serialize and rotate.
module shift_reg_ctrl
   import shift_reg_ctrl_pkg::*;
#(
   parameter int   CW   = 3,
   parameter logic FILL = 1'b0
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          REQ_VALID,
   output logic          REQ_READY,
   input  logic [1:0]    REQ_OP,
   input  logic          REQ_DIR,
   input  logic [3:0]    REQ_DATA,
   input  logic [CW-1:0] REQ_COUNT,
   input  logic          HOLD,
   output logic          REG_ENB,
   output logic [1:0]    REG_MODO,
   output logic          REG_DIR,
   output logic [3:0]    REG_D,
   output logic          REG_S_IN,
   input  logic          REG_S_OUT,
   output logic          SER_OUT,
   output logic          SER_VALID,
   output logic          BUSY,
   output logic          DONE
);
   state_t        state, nxt;
   logic [1:0]    op;
   logic          dir;
   logic [3:0]    data;
   logic [CW-1:0] count;
   logic          last, step;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state <= IDLE;
         op    <= '0;
         dir   <= 1'b0;
         data  <= '0;
         count <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && REQ_VALID) begin
            op    <= REQ_OP;
            dir   <= REQ_DIR;
            data  <= REQ_DATA;
            count <= REQ_COUNT;
         end
      end
   assign step = (state == SHIFT || state == ROTATE) && !HOLD;
   shift_step_counter #(.W(CW + 1)) u_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .load  (state == LOAD),
      .en    (step),
      .value (op == OP_SER ? (CW + 1)'(SER_BITS) : {1'b0, count}),
      .last  (last)
   );
   always_comb begin
      nxt       = state;
      REQ_READY = 1'b0;
      REG_ENB   = 1'b0;
      REG_MODO  = MODO_SHIFT;
      REG_DIR   = 1'b0;
      REG_S_IN  = 1'b0;
      SER_VALID = 1'b0;
      DONE      = 1'b0;
      case (state)
         IDLE: begin
            REQ_READY = 1'b1;
            if (REQ_VALID) nxt = LOAD;
         end
         LOAD: begin
            REG_ENB  = 1'b1;
            REG_MODO = MODO_LOAD;
            nxt = op == OP_SER ? SHIFT : (op == OP_ROT && count != '0) ? ROTATE : FIN;
         end
         SHIFT: begin
            REG_DIR   = dir;
            REG_S_IN  = FILL;
            REG_ENB   = !HOLD;
            SER_VALID = !HOLD;
            if (step && last) nxt = FIN;
         end
         ROTATE: begin
            REG_MODO = MODO_ROTATE;
            REG_DIR  = dir;
            REG_ENB  = !HOLD;
            if (step && last) nxt = FIN;
         end
         FIN: begin
            DONE = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   assign BUSY    = state != IDLE;
   assign REG_D   = data;
   assign SER_OUT = REG_S_OUT;
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: drives commands into shift_reg_ctrl with a behavioural register4 attached.
module tb_shift_reg_ctrl;
   localparam int CW = 3;
   logic          CLK = 1'b0, RST_N = 1'b0, REQ_VALID = 1'b0, REQ_DIR = 1'b0, HOLD = 1'b0;
   logic [1:0]    REQ_OP = '0;
   logic [3:0]    REQ_DATA = '0;
   logic [CW-1:0] REQ_COUNT = '0;
   logic          REQ_READY, REG_ENB, REG_DIR, REG_S_IN, REG_S_OUT, SER_OUT, SER_VALID, BUSY, DONE;
   logic [1:0]    REG_MODO;
   logic [3:0]    REG_D;
   logic [3:0]    q = '0;
   logic [3:0]    q_done;
   logic [12:0]   outs;
   localparam logic [12:0] IDLE_OUTS = 13'b1_0_0_00_0_0000_0_0_0;
   int   compared = 0, mismatched = 0, lat;
   bit   done_seen, busy_bad;
   logic exp_q[$], obs_q[$];

   shift_reg_ctrl #(.CW(CW), .FILL(1'b0)) dut (
      .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_OP(REQ_OP), .REQ_DIR(REQ_DIR), .REQ_DATA(REQ_DATA), .REQ_COUNT(REQ_COUNT),
      .HOLD(HOLD), .REG_ENB(REG_ENB), .REG_MODO(REG_MODO), .REG_DIR(REG_DIR),
      .REG_D(REG_D), .REG_S_IN(REG_S_IN), .REG_S_OUT(REG_S_OUT), .SER_OUT(SER_OUT),
      .SER_VALID(SER_VALID), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;
   assign outs = {REQ_READY, BUSY, REG_ENB, REG_MODO, REG_DIR, REG_D, REG_S_IN, SER_VALID, DONE};

   // register4 model: the bit about to leave is presented on S_OUT
   assign REG_S_OUT = REG_DIR ? q[0] : q[3];
   always @(posedge CLK)
      if (REG_ENB)
         case (REG_MODO)
            2'b10: q <= REG_D;
            2'b00: q <= REG_DIR ? {REG_S_IN, q[3:1]} : {q[2:0], REG_S_IN};
            2'b01: q <= REG_DIR ? {q[0], q[3:1]} : {q[2:0], q[3]};
            default: q <= q;
         endcase

   task automatic send(input logic [1:0] op, input logic d, input logic [3:0] data,
                       input logic [CW-1:0] cnt, input bit keep);
      @(negedge CLK);
      REQ_VALID = 1'b1; REQ_OP = op; REQ_DIR = d; REQ_DATA = data; REQ_COUNT = cnt;
      @(posedge CLK);
      #1 if (!keep) REQ_VALID = 1'b0;
   endtask

   // lat counts cycles from the first cycle after the accepting edge through the DONE cycle
   task automatic wait_done(input int hold_from, input int hold_len);
      lat = 0; done_seen = 0; busy_bad = 0; obs_q.delete();
      while (!done_seen && lat < 40) begin
         @(negedge CLK);
         lat++;
         if (REQ_READY !== 1'b0 || BUSY !== 1'b1) busy_bad = 1;
         if (SER_VALID === 1'b1) obs_q.push_back(SER_OUT);
         if (DONE === 1'b1) begin done_seen = 1; q_done = q; end
         HOLD = (lat + 1 >= hold_from) && (lat + 1 < hold_from + hold_len);
      end
      HOLD = 1'b0;
   endtask

   task automatic test_reset;
      bit toggled = 0;
      #3;
      compared++;
      if (outs !== IDLE_OUTS) begin
         mismatched++; $display("FAIL reset_outs got %b want %b", outs, IDLE_OUTS);
      end
      @(negedge CLK); RST_N = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         if (outs !== IDLE_OUTS) toggled = 1;
      end
      compared++;
      if (toggled) begin
         mismatched++; $display("FAIL idle_quiet got toggled=1 want toggled=0");
      end
   endtask

   task automatic test_serialize(input logic d, input logic [3:0] data, input int hf,
                                 input int hl, input int exp_lat);
      logic e, o;
      for (int i = 0; i < 4; i++) exp_q.push_back(d ? data[i] : data[3-i]);
      send(2'b01, d, data, '0, 0);
      wait_done(hf, hl);
      compared++;
      if (!done_seen) begin mismatched++; $display("FAIL ser_done timeout got none want DONE"); end
      compared++;
      if (lat !== exp_lat) begin mismatched++; $display("FAIL ser_latency got %0d want %0d", lat, exp_lat); end
      compared++;
      if (q_done !== 4'b0000) begin mismatched++; $display("FAIL ser_q got %b want 0000", q_done); end
      compared++;
      if (busy_bad) begin mismatched++; $display("FAIL ser_busy got ready/busy wrong want ready=0 busy=1"); end
      compared++;
      if (obs_q.size() !== exp_q.size()) begin
         mismatched++; $display("FAIL ser_bitcount got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         o = obs_q.size() > 0 ? obs_q.pop_front() : 1'bx;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL ser_bit%0d got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_rotate;
      logic        dr  [5];
      logic [3:0]  dat [5];
      logic [CW-1:0] cn [5];
      int          hf  [5];
      logic [3:0]  eq  [5];
      int          el  [5];
      dr  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      dat = '{4'b0001, 4'b0001, 4'b1010, 4'b0011, 4'b0001};
      cn  = '{3'd3, 3'd2, 3'd0, 3'd2, 3'd7};
      hf  = '{0, 0, 0, 3, 0};
      eq  = '{4'b1000, 4'b0100, 4'b1010, 4'b1100, 4'b1000};
      el  = '{5, 4, 2, 5, 9};
      for (int i = 0; i < 5; i++) begin
         send(2'b10, dr[i], dat[i], cn[i], 0);
         wait_done(hf[i], hf[i] > 0 ? 1 : 0);
         compared++;
         if (lat !== el[i] || !done_seen) begin
            mismatched++; $display("FAIL rot%0d_latency got %0d want %0d", i, lat, el[i]);
         end
         compared++;
         if (q_done !== eq[i]) begin mismatched++; $display("FAIL rot%0d_q got %b want %b", i, q_done, eq[i]); end
         compared++;
         if (obs_q.size() !== 0) begin
            mismatched++; $display("FAIL rot%0d_servalid got %0d bits want 0", i, obs_q.size());
         end
      end
   endtask

   task automatic test_load;
      send(2'b00, 1'b0, 4'b0110, '0, 0);
      wait_done(0, 0);
      compared++;
      if (lat !== 2 || q_done !== 4'b0110) begin
         mismatched++; $display("FAIL load got lat=%0d q=%b want lat=2 q=0110", lat, q_done);
      end
      send(2'b11, 1'b1, 4'b1001, 3'd5, 0);
      wait_done(0, 0);
      compared++;
      if (lat !== 2 || q_done !== 4'b1001) begin
         mismatched++; $display("FAIL reserved_op got lat=%0d q=%b want lat=2 q=1001", lat, q_done);
      end
      @(negedge CLK);
      compared++;
      if (DONE !== 1'b0 || REQ_READY !== 1'b1) begin
         mismatched++; $display("FAIL done_pulse got done=%b ready=%b want done=0 ready=1", DONE, REQ_READY);
      end
   endtask

   task automatic test_back_to_back;
      logic e, o;
      send(2'b00, 1'b0, 4'b0110, '0, 1);
      REQ_OP = 2'b01; REQ_DIR = 1'b0; REQ_DATA = 4'b1011;
      wait_done(0, 0);
      compared++;
      if (lat !== 2 || q_done !== 4'b0110 || busy_bad) begin
         mismatched++; $display("FAIL b2b_first got lat=%0d q=%b busy_bad=%0d want 2 0110 0", lat, q_done, busy_bad);
      end
      @(negedge CLK);
      compared++;
      if (REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
         mismatched++; $display("FAIL b2b_gap got ready=%b busy=%b want ready=1 busy=0", REQ_READY, BUSY);
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(REQ_DATA[3-i]);
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      wait_done(0, 0);
      compared++;
      if (lat !== 6 || q_done !== 4'b0000 || busy_bad) begin
         mismatched++; $display("FAIL b2b_second got lat=%0d q=%b busy_bad=%0d want 6 0000 0", lat, q_done, busy_bad);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.size() > 0 ? obs_q.pop_front() : 1'bx;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL b2b_bit got %b want %b", o, e); end
      end
   endtask

   task automatic test_reset_mid;
      bit done_hit = 0;
      send(2'b01, 1'b0, 4'b1011, '0, 0);
      repeat (2) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      compared++;
      if (outs !== IDLE_OUTS) begin
         mismatched++; $display("FAIL midreset_outs got %b want %b", outs, IDLE_OUTS);
      end
      repeat (3) begin
         @(negedge CLK);
         if (DONE !== 1'b0) done_hit = 1;
      end
      compared++;
      if (done_hit) begin mismatched++; $display("FAIL midreset_done got DONE pulse want none"); end
      RST_N = 1'b1;
      send(2'b00, 1'b0, 4'b1001, '0, 0);
      wait_done(0, 0);
      compared++;
      if (lat !== 2 || q_done !== 4'b1001 || !done_seen) begin
         mismatched++; $display("FAIL after_reset got lat=%0d q=%b want lat=2 q=1001", lat, q_done);
      end
   endtask

   initial begin
      test_reset;
      test_serialize(1'b0, 4'b1011, 0, 0, 6);
      test_serialize(1'b1, 4'b1011, 3, 2, 8);
      test_rotate;
      test_load;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
